pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Owns the architectural PC register and drives instruction fetch.
- Sends `pc` to the combinational PC adder and takes back `pc_4` as the sequential next address.
- Applies jump/branch redirects using the same 2-bit `jump` encoding as the adder, handshakes with instruction memory, and presents {pc, instruction, valid} to the IF/ID stage.
- Honours hazard-unit stalls.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, value driven on if_instr when reset or invalid.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
pc_4  input  32  next sequential address from the PC adder (pc+4, mod 2^32).
jump  input  2  redirect select: 00 none; 01 or 11 take jump_add; 10 take jump_forward_add.
jump_add  input  32  jump target.
jump_forward_add  input  32  forwarded branch/jump target.
stall  input  1  hazard unit: IF/ID must hold its current contents.
imem_req  output  1  fetch request; address is imem_addr.
imem_addr  output  32  fetch address, always equal to pc.
imem_ack  input  1  memory response valid this cycle; same-cycle or multi-cycle latency allowed.
imem_rdata  input  32  instruction word, valid when imem_ack=1.
pc  output  32  current PC register, fed to the PC adder.
if_valid  output  1  IF/ID slot holds a valid instruction.
if_pc  output  32  address of if_instr.
if_instr  output  32  fetched instruction.

Behaviour:
- Reset (async assert, sync deassert use):
  - pc=RESET_PC, state=BOOT, imem_req=0.
  - if_valid=0, if_pc=0, if_instr=NOP_INSTR, hold buffer cleared.
  - Reset mid-request abandons the transaction; any late imem_ack is ignored while in BOOT.
- Target selection: target = jump_add if jump[0]=1, else jump_forward_add if jump=10. target[1:0] is forced to 00. Redirect is asserted when jump != 00.
- Slot free = !if_valid || !stall. Consume: if_valid && !stall at a clock edge means IF/ID took the word; if nothing new loads, if_valid<=0.
- States:
  - BOOT: imem_req=0. Next cycle goes to REQ. A redirect here loads pc<=target.
  - REQ: imem_req=1. The request stays asserted with a stable address until ack, unless a redirect arrives.
    - Ack, no redirect, slot free: if_pc<=pc, if_instr<=imem_rdata, if_valid<=1, pc<=pc_4, stay REQ. Gives back-to-back fetch with single-cycle memory.
    - Ack, no redirect, slot not free: capture {pc, rdata} in hold buffer, pc<=pc_4, go HOLD.
    - Redirect, no ack: pending<=target, if_valid<=0, go DRAIN.
    - Redirect with ack same cycle: discard rdata, pc<=target, if_valid<=0, stay REQ.
  - HOLD: imem_req=0.
    - When stall=0: IF/ID<=hold buffer, if_valid=1, go REQ.
    - A redirect in HOLD beats stall: drop hold buffer, if_valid<=0, pc<=target, go REQ.
  - DRAIN: imem_req=1 (old address held stable until ack).
    - Further redirects overwrite pending; the latest wins.
    - On ack: discard rdata, pc<=pending, go REQ. A redirect in the ack cycle supplies pc<=target instead.
- Redirect always flushes IF/ID (if_valid<=0), regardless of stall.
- No instruction fetched from a superseded path ever reaches if_valid=1.
- Wrap-around: pc 32'hFFFF_FFFC advances to 32'h0000_0000 via pc_4. No exception is raised.
- Output reset values hold until the first load. if_instr is not cleared on flush; only if_valid drops.

Test Plan:
1. Reset, then 1-cycle-ack memory, stall=0 -> imem_addr 0,4,8,… on consecutive cycles. if_valid=1 from cycle 2 with if_pc trailing imem_addr by one.
2. stall=1 for 3 cycles while if_valid=1 and ack arrives -> IF/ID holds, pc advances once, imem_req=0. On release the held word appears next cycle with no loss or duplicate.
3. jump=01, jump_add=32'h0000_0100 at pc=8 with ack -> rdata discarded, if_valid=0 next cycle, next imem_addr=0x100. jump=10 selects jump_forward_add; jump=11 selects jump_add.
4. 3-cycle-latency memory, redirect to 0x40 in first wait cycle, second redirect to 0x80 next cycle -> address held until ack, response dropped, next fetch at 0x80.
5. pc preset via redirect to 32'hFFFF_FFFC -> following fetch address 0x0000_0000. Target 0x103 is fetched as 0x100.
6. Assert reset_n=0 mid-wait (DRAIN) -> outputs return to reset values immediately (async). After release, fetch restarts at RESET_PC; a stale ack in BOOT is ignored.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the architectural PC, issues instruction fetches,
// applies jump/branch redirects and presents {pc, instr, valid} to IF/ID.
// A small FSM tracks whether a fetch is outstanding (REQ), whether a
// returned word is parked because IF/ID is stalled (HOLD), or whether an
// old-path fetch must be drained after a redirect (DRAIN).
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_4,
  input  logic [1:0]  jump,
  input  logic [31:0] jump_add,
  input  logic [31:0] jump_forward_add,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] pending;
  logic [31:0] pending_next;
  logic [31:0] hold_pc;
  logic [31:0] hold_pc_next;
  logic [31:0] hold_instr;
  logic [31:0] hold_instr_next;
  logic        if_valid_next;
  logic [31:0] if_pc_next;
  logic [31:0] if_instr_next;

  logic [31:0] target;
  logic        redirect;
  logic        slot_free;

  // The memory always sees the architectural PC; the address only moves
  // when the FSM updates pc, so it stays stable while a request waits.
  assign imem_addr = pc;

  // Redirect target decode: jump[0] picks jump_add (01 and 11), 10 picks the
  // forwarded target; the low two bits are cleared to keep word alignment.
  always_comb begin
    target    = (jump[0] ? jump_add : jump_forward_add) & 32'hFFFF_FFFC;
    redirect  = (jump != 2'b00);
    slot_free = !if_valid || !stall;
  end

  // Next-state and datapath decisions; every target defaults to "hold".
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    pending_next    = pending;
    hold_pc_next    = hold_pc;
    hold_instr_next = hold_instr;
    if_valid_next   = if_valid && stall;
    if_pc_next      = if_pc;
    if_instr_next   = if_instr;
    imem_req        = 1'b0;

    case (state)
      BOOT: begin
        state_next = REQ;
        if (redirect) begin
          pc_next       = target;
          if_valid_next = 1'b0;
        end
      end

      REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          if_valid_next = 1'b0;
          if (imem_ack) begin
            pc_next = target;
          end else begin
            pending_next = target;
            state_next   = DRAIN;
          end
        end else if (imem_ack) begin
          pc_next = pc_4;
          if (slot_free) begin
            if_valid_next = 1'b1;
            if_pc_next    = pc;
            if_instr_next = imem_rdata;
          end else begin
            hold_pc_next    = pc;
            hold_instr_next = imem_rdata;
            state_next      = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          if_valid_next   = 1'b0;
          pc_next         = target;
          hold_pc_next    = 32'h0000_0000;
          hold_instr_next = NOP_INSTR;
          state_next      = REQ;
        end else if (!stall) begin
          if_valid_next = 1'b1;
          if_pc_next    = hold_pc;
          if_instr_next = hold_instr;
          state_next    = REQ;
        end
      end

      DRAIN: begin
        imem_req = 1'b1;
        if (redirect) begin
          if_valid_next = 1'b0;
        end
        if (imem_ack) begin
          pc_next    = redirect ? target : pending;
          state_next = REQ;
        end else if (redirect) begin
          pending_next = target;
        end
      end

      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // State, PC, pending target, hold buffer and IF/ID registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      pending    <= RESET_PC;
      hold_pc    <= 32'h0000_0000;
      hold_instr <= NOP_INSTR;
      if_valid   <= 1'b0;
      if_pc      <= 32'h0000_0000;
      if_instr   <= NOP_INSTR;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      pending    <= pending_next;
      hold_pc    <= hold_pc_next;
      hold_instr <= hold_instr_next;
      if_valid   <= if_valid_next;
      if_pc      <= if_pc_next;
      if_instr   <= if_instr_next;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed, table-driven bench for pc_fetch_unit with a few hand-written
// multi-cycle sequences (long-latency drain, async reset mid-drain).
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int NVEC = 23;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc_4;
  logic [1:0]  jump;
  logic [31:0] jump_add;
  logic [31:0] jump_forward_add;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int checks;
  int errors;

  typedef struct packed {
    logic        stall;
    logic [1:0]  jump;
    logic [31:0] jadd;
    logic [31:0] jfadd;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_ifpc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs [NVEC];

  pc_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pc_4            (pc_4),
    .jump            (jump),
    .jump_add        (jump_add),
    .jump_forward_add(jump_forward_add),
    .stall           (stall),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .pc              (pc),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr)
  );

  // Combinational PC adder stand-in (wraps modulo 2^32)
  assign pc_4 = pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic vec_t mk(input logic s, input logic [1:0] j,
                              input logic [31:0] ja, input logic [31:0] jf,
                              input logic a, input logic [31:0] r,
                              input logic [31:0] epc, input logic ereq,
                              input logic ev, input logic [31:0] eifpc,
                              input logic [31:0] einstr);
    vec_t v;
    v.stall = s;  v.jump = j; v.jadd = ja; v.jfadd = jf;
    v.ack = a;    v.rdata = r;
    v.e_pc = epc; v.e_req = ereq; v.e_valid = ev;
    v.e_ifpc = eifpc; v.e_instr = einstr;
    return v;
  endfunction

  task automatic applyStimulus(input logic s, input logic [1:0] j,
                               input logic [31:0] ja, input logic [31:0] jf,
                               input logic a, input logic [31:0] r);
    stall            = s;
    jump             = j;
    jump_add         = ja;
    jump_forward_add = jf;
    imem_ack         = a;
    imem_rdata       = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] epc,
                           input logic ereq, input logic ev,
                           input logic [31:0] eifpc, input logic [31:0] einstr);
    checkOutput({tag, ".pc"},        pc,                 epc);
    checkOutput({tag, ".imem_addr"}, imem_addr,          epc);
    checkOutput({tag, ".imem_req"},  {31'd0, imem_req},  {31'd0, ereq});
    checkOutput({tag, ".if_valid"},  {31'd0, if_valid},  {31'd0, ev});
    checkOutput({tag, ".if_pc"},     if_pc,              eifpc);
    checkOutput({tag, ".if_instr"},  if_instr,           einstr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);

    // Single-cycle memory, back-to-back fetch, stall/hold, redirects, wrap
    vecs[0]  = mk(0, 2'b00, 32'h0,   32'h0,   1, 32'hDEAD_BEEF, 32'h0,   1, 0, 32'h0, NOP);
    vecs[1]  = mk(0, 2'b00, 32'h0,   32'h0,   1, rd(32'h0),   32'h4,   1, 1, 32'h0,   rd(32'h0));
    vecs[2]  = mk(0, 2'b00, 32'h0,   32'h0,   1, rd(32'h4),   32'h8,   1, 1, 32'h4,   rd(32'h4));
    vecs[3]  = mk(0, 2'b00, 32'h0,   32'h0,   1, rd(32'h8),   32'hC,   1, 1, 32'h8,   rd(32'h8));
    vecs[4]  = mk(1, 2'b00, 32'h0,   32'h0,   1, rd(32'hC),   32'h10,  0, 1, 32'h8,   rd(32'h8));
    vecs[5]  = mk(1, 2'b00, 32'h0,   32'h0,   0, 32'h0,       32'h10,  0, 1, 32'h8,   rd(32'h8));
    vecs[6]  = mk(1, 2'b00, 32'h0,   32'h0,   0, 32'h0,       32'h10,  0, 1, 32'h8,   rd(32'h8));
    vecs[7]  = mk(0, 2'b00, 32'h0,   32'h0,   0, 32'h0,       32'h10,  1, 1, 32'hC,   rd(32'hC));
    vecs[8]  = mk(0, 2'b00, 32'h0,   32'h0,   1, rd(32'h10),  32'h14,  1, 1, 32'h10,  rd(32'h10));
    vecs[9]  = mk(0, 2'b01, 32'h100, 32'h200, 1, rd(32'h14),  32'h100, 1, 0, 32'h10,  rd(32'h10));
    vecs[10] = mk(0, 2'b00, 32'h0,   32'h0,   1, rd(32'h100), 32'h104, 1, 1, 32'h100, rd(32'h100));
    vecs[11] = mk(0, 2'b10, 32'h300, 32'h200, 1, rd(32'h104), 32'h200, 1, 0, 32'h100, rd(32'h100));
    vecs[12] = mk(0, 2'b11, 32'h300, 32'h500, 0, 32'h0,       32'h200, 1, 0, 32'h100, rd(32'h100));
    vecs[13] = mk(0, 2'b00, 32'h0,   32'h0,   1, rd(32'h200), 32'h300, 1, 0, 32'h100, rd(32'h100));
    vecs[14] = mk(0, 2'b00, 32'h0,   32'h0,   1, rd(32'h300), 32'h304, 1, 1, 32'h300, rd(32'h300));
    vecs[15] = mk(0, 2'b01, 32'h103, 32'h0,   1, rd(32'h304), 32'h100, 1, 0, 32'h300, rd(32'h300));
    vecs[16] = mk(0, 2'b01, 32'hFFFF_FFFC, 32'h0, 1, rd(32'h100), 32'hFFFF_FFFC, 1, 0, 32'h300, rd(32'h300));
    vecs[17] = mk(0, 2'b00, 32'h0,   32'h0,   1, 32'h1234_5678, 32'h0, 1, 1, 32'hFFFF_FFFC, 32'h1234_5678);
    vecs[18] = mk(1, 2'b00, 32'h0,   32'h0,   1, rd(32'h0),   32'h4,   0, 1, 32'hFFFF_FFFC, 32'h1234_5678);
    vecs[19] = mk(1, 2'b10, 32'h0,   32'h50,  0, 32'h0,       32'h50,  1, 0, 32'hFFFF_FFFC, 32'h1234_5678);
    vecs[20] = mk(1, 2'b00, 32'h0,   32'h0,   1, rd(32'h50),  32'h54,  1, 1, 32'h50,  rd(32'h50));
    vecs[21] = mk(1, 2'b00, 32'h0,   32'h0,   0, 32'h0,       32'h54,  1, 1, 32'h50,  rd(32'h50));
    vecs[22] = mk(0, 2'b00, 32'h0,   32'h0,   0, 32'h0,       32'h54,  1, 0, 32'h50,  rd(32'h50));

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'h0, 1'b0, 1'b0, 32'h0, NOP);
    reset_n = 1'b1;
    check_all("boot", 32'h0, 1'b0, 1'b0, 32'h0, NOP);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].jump, vecs[i].jadd, vecs[i].jfadd,
                    vecs[i].ack, vecs[i].rdata);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_req,
                vecs[i].e_valid, vecs[i].e_ifpc, vecs[i].e_instr);
    end

    // Long-latency memory: two redirects while waiting, latest wins
    applyStimulus(1'b0, 2'b01, 32'h40, 32'h0, 1'b0, 32'h0);
    step();
    check_all("drain_a", 32'h54, 1'b1, 1'b0, 32'h50, rd(32'h50));
    applyStimulus(1'b0, 2'b10, 32'h40, 32'h80, 1'b0, 32'h0);
    step();
    check_all("drain_b", 32'h54, 1'b1, 1'b0, 32'h50, rd(32'h50));
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'hBAD0_0054);
    step();
    check_all("drain_c", 32'h80, 1'b1, 1'b0, 32'h50, rd(32'h50));
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, rd(32'h80));
    step();
    check_all("drain_d", 32'h84, 1'b1, 1'b1, 32'h80, rd(32'h80));

    // Async reset while draining, then stale ack during BOOT
    applyStimulus(1'b0, 2'b01, 32'h200, 32'h0, 1'b0, 32'h0);
    step();
    check_all("rst_pre", 32'h84, 1'b1, 1'b0, 32'h80, rd(32'h80));
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'hBAD0_0084);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_all("rst_async", 32'h0, 1'b0, 1'b0, 32'h0, NOP);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_all("rst_boot", 32'h0, 1'b0, 1'b0, 32'h0, NOP);
    step();
    check_all("rst_stale", 32'h0, 1'b1, 1'b0, 32'h0, NOP);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, rd(32'h0));
    step();
    check_all("rst_fetch", 32'h4, 1'b1, 1'b1, 32'h0, rd(32'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
